pattern_tx: RTL and testbench

PATTERN_TX -- requirements
Module: pattern_tx

---
 rtl/pattern_tx.sv | 128 ++++++++++++
 tb/tb_pattern_tx.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_tx.sv
// Framed serial transmitter: preamble, MSB-first payload, optional even parity, one gap bit.
// Define PATTERN_TX_PARITY_EN to insert the parity state between payload and gap.
module pattern_tx #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned PRE_W = 4,
   parameter logic [PRE_W-1:0] PREAMBLE = 4'b1011
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              valid,
   input  logic [DATA_W-1:0] data,
   output logic              ready,
   output logic              out,
   output logic              busy,
   output logic              done,
   output logic [2:0]        phase
);

   localparam int unsigned FW = PRE_W + DATA_W;
   localparam int unsigned CW = 5;
   localparam logic [CW-1:0] PRE_LAST = CW'(PRE_W - 1);
   localparam logic [CW-1:0] DATA_LAST = CW'(DATA_W - 1);

   typedef enum logic [2:0] {
      StIdle = 3'd0,
      StPre  = 3'd1,
      StData = 3'd2,
      StPar  = 3'd3,
      StGap  = 3'd4
   } state_t;

   state_t          state;
   logic [FW-1:0]   frame_sr;
   logic [CW-1:0]   cnt;
   logic [CW-1:0]   cnt_inc;
   logic [FW-1:0]   frame_load;
   logic            out_q;
   logic            done_q;
`ifdef PATTERN_TX_PARITY_EN
   logic            par_q;
`endif

   assign frame_load = {PREAMBLE, data};
   assign cnt_inc    = (cnt == '1) ? cnt : cnt + 1'b1;

   assign ready = (state == StIdle);
   assign busy  = (state != StIdle);
   assign phase = state;
   assign out   = out_q;
   assign done  = done_q;

   // Preamble and payload share one shift register; out is registered so the first
   // preamble bit appears in the cycle right after acceptance.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= StIdle;
         frame_sr <= '0;
         cnt      <= '0;
         out_q    <= 1'b0;
         done_q   <= 1'b0;
`ifdef PATTERN_TX_PARITY_EN
         par_q    <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state)
            StIdle: begin
               out_q <= 1'b0;
               if (valid) begin
                  frame_sr <= frame_load << 1;
                  out_q    <= frame_load[FW-1];
`ifdef PATTERN_TX_PARITY_EN
                  par_q    <= ^data;
`endif
                  cnt      <= '0;
                  state    <= StPre;
               end
            end
            StPre: begin
               out_q    <= frame_sr[FW-1];
               frame_sr <= frame_sr << 1;
               if (cnt == PRE_LAST) begin
                  cnt   <= '0;
                  state <= StData;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            StData: begin
               if (cnt == DATA_LAST) begin
                  cnt <= '0;
`ifdef PATTERN_TX_PARITY_EN
                  out_q <= par_q;
                  state <= StPar;
`else
                  out_q  <= 1'b0;
                  done_q <= 1'b1;
                  state  <= StGap;
`endif
               end else begin
                  out_q    <= frame_sr[FW-1];
                  frame_sr <= frame_sr << 1;
                  cnt      <= cnt_inc;
               end
            end
`ifdef PATTERN_TX_PARITY_EN
            StPar: begin
               cnt    <= '0;
               out_q  <= 1'b0;
               done_q <= 1'b1;
               state  <= StGap;
            end
`endif
            StGap: begin
               cnt   <= '0;
               out_q <= 1'b0;
               state <= StIdle;
            end
            default: begin
               cnt   <= '0;
               out_q <= 1'b0;
               state <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pattern_tx.sv
// Scoreboard bench for pattern_tx: per-cycle expected {phase, done, out} queued at acceptance.
module tb_pattern_tx;

   localparam int DATA_W = 8;
   localparam int PRE_W = 4;
   localparam logic [PRE_W-1:0] PREAMBLE = 4'b1011;
`ifdef PATTERN_TX_PARITY_EN
   localparam int PAR_LEN = 1;
   localparam logic [31:0] A5_BITS = 32'b1011_10100101_0_0;
   localparam logic [31:0] H07_BITS = 32'b1011_00000111_1_0;
`else
   localparam int PAR_LEN = 0;
   localparam logic [31:0] A5_BITS = 32'b1011_10100101_0;
   localparam logic [31:0] H07_BITS = 32'b1011_00000111_0;
`endif
   localparam int FLEN = PRE_W + DATA_W + 1 + PAR_LEN;

   logic              clk = 1'b0;
   logic              reset;
   logic              valid;
   logic [DATA_W-1:0] data;
   logic              ready;
   logic              out;
   logic              busy;
   logic              done;
   logic [2:0]        phase;

   pattern_tx #(
      .DATA_W  (DATA_W),
      .PRE_W   (PRE_W),
      .PREAMBLE(PREAMBLE)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .valid(valid),
      .data (data),
      .ready(ready),
      .out  (out),
      .busy (busy),
      .done (done),
      .phase(phase)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [2:0] det_next(input logic [2:0] s, input logic b);
      case (s)
         3'd0: return b ? 3'd1 : 3'd0;
         3'd1: return b ? 3'd1 : 3'd2;
         3'd2: return b ? 3'd3 : 3'd0;
         3'd3: return b ? 3'd4 : 3'd2;
         3'd4: return b ? 3'd1 : 3'd2;
         default: return 3'd0;
      endcase
   endfunction

   logic [4:0]  sb_q[$];
   logic [4:0]  e;
   logic [2:0]  det = 3'd0;
   logic [31:0] cur_bits = '0;
   logic [31:0] done_bits = '0;
   int          cur_len = 0;
   int          done_len = 0;
   int          cycle = 0;
   int          acc_cnt = 0;
   int          done_cnt = 0;
   int          last_acc = 0;
   int          acc_gap = 0;
   int          pre_run = 0;

   always @(negedge clk) begin
      cycle++;
      if (reset) begin
         sb_q.delete();
         pre_run = 0;
         det = 3'd0;
      end else begin
         det = det_next(det, out);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_eq("out", {31'd0, out}, {31'd0, e[0]});
            check_eq("done", {31'd0, done}, {31'd0, e[1]});
            check_eq("phase", {29'd0, phase}, {29'd0, e[4:2]});
            check_eq("busy", {31'd0, busy}, 32'd1);
            check_eq("ready_busy", {31'd0, ready}, 32'd0);
            cur_bits = {cur_bits[30:0], out};
            cur_len++;
            if (e[1]) begin
               done_bits = cur_bits;
               done_len = cur_len;
            end
            pre_run = (phase == 3'd1) ? pre_run + 1 : 0;
            if (pre_run == PRE_W) check_eq("det_1011", {29'd0, det}, 32'd4);
         end else begin
            check_eq("idle_out", {31'd0, out}, 32'd0);
            check_eq("idle_busy", {31'd0, busy}, 32'd0);
            check_eq("idle_done", {31'd0, done}, 32'd0);
            check_eq("idle_phase", {29'd0, phase}, 32'd0);
            check_eq("idle_ready", {31'd0, ready}, 32'd1);
         end
         if (done) done_cnt++;
         if (valid && ready) begin
            acc_cnt++;
            acc_gap = cycle - last_acc;
            last_acc = cycle;
            cur_bits = '0;
            cur_len = 0;
            for (int i = PRE_W - 1; i >= 0; i--) sb_q.push_back({3'd1, 1'b0, PREAMBLE[i]});
            for (int i = DATA_W - 1; i >= 0; i--) sb_q.push_back({3'd2, 1'b0, data[i]});
`ifdef PATTERN_TX_PARITY_EN
            sb_q.push_back({3'd3, 1'b0, ^data});
            sb_q.push_back({3'd4, 1'b1, 1'b0});
`else
            sb_q.push_back({3'd4, 1'b1, 1'b0});
`endif
         end
      end
   end

   task automatic send(input logic [DATA_W-1:0] d);
      valid = 1'b1;
      data  = d;
      @(posedge clk);
      #1;
      valid = 1'b0;
      data  = DATA_W'($urandom);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 100 && !ready; i++) begin
         @(posedge clk);
         #1;
      end
      check_eq("idle_timeout", {31'd0, ready}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   int base_acc;
   int base_done;
   logic [DATA_W-1:0] frames[5] = '{8'hA5, 8'h00, 8'hFF, 8'h07, 8'h3C};

   initial begin
      reset = 1'b1;
      valid = 1'b0;
      data  = '0;
      @(posedge clk);
      @(posedge clk);
      #1;
      check_eq("rst_ready", {31'd0, ready}, 32'd1);
      check_eq("rst_out", {31'd0, out}, 32'd0);
      check_eq("rst_busy", {31'd0, busy}, 32'd0);
      check_eq("rst_done", {31'd0, done}, 32'd0);
      check_eq("rst_phase", {29'd0, phase}, 32'd0);
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Single frames, payload scrambled right after acceptance
      base_done = done_cnt;
      foreach (frames[k]) begin
         send(frames[k]);
         wait_idle();
         check_eq("frame_len", done_len, FLEN);
         if (frames[k] == 8'hA5) check_eq("a5_bits", done_bits, A5_BITS);
         if (frames[k] == 8'h07) check_eq("h07_bits", done_bits, H07_BITS);
      end
      check_eq("done_pulses", done_cnt - base_done, 5);

      // Data changes after acceptance while valid stays high
      base_acc = acc_cnt;
      valid = 1'b1;
      data  = 8'hA5;
      @(posedge clk);
      #1;
      data = 8'hFF;
      for (int i = 0; i < 40 && acc_cnt < base_acc + 2; i++) begin
         @(posedge clk);
         #1;
      end
      valid = 1'b0;
      check_eq("b2b_accepts", acc_cnt - base_acc, 2);
      check_eq("b2b_spacing", acc_gap, FLEN + 1);
      check_eq("b2b_a5_bits", done_bits, A5_BITS);
      wait_idle();

      // Asynchronous reset during the third payload bit
      send(8'hA5);
      repeat (PRE_W + 2) @(posedge clk);
      #3;
      check_eq("pre_rst_phase", {29'd0, phase}, 32'd2);
      reset = 1'b1;
      #1;
      check_eq("async_out", {31'd0, out}, 32'd0);
      check_eq("async_phase", {29'd0, phase}, 32'd0);
      check_eq("async_ready", {31'd0, ready}, 32'd1);
      check_eq("async_busy", {31'd0, busy}, 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check_eq("post_rst_out", {31'd0, out}, 32'd0);
      check_eq("post_rst_phase", {29'd0, phase}, 32'd0);

      // Valid held for 40 cycles
      base_acc  = acc_cnt;
      base_done = done_cnt;
      valid = 1'b1;
      data  = 8'h3C;
      repeat (40) @(posedge clk);
      #1;
      valid = 1'b0;
      wait_idle();
      check_eq("hold_accepts", acc_cnt - base_acc, 3);
      check_eq("hold_dones", done_cnt - base_done, 3);
      check_eq("hold_spacing", acc_gap, FLEN + 1);

      repeat (3) @(posedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
